// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART TX block and the future RX block.
//   tx_state_t    : frame FSM states (PARITY is used only when parity is compiled in)
//   UART_DATA_BITS: data bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a first-word-fall-through read port and registered
//   status flags. Pushes while full and pops while empty are ignored.
//   Ports:
//     i_clk, i_rst_n : clock and synchronous active-low reset
//     i_push, i_data : write request and data
//     i_pop          : read request; o_data always shows the head entry
//     o_full, o_empty, o_level : occupancy status after the current edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = i_push && !full_q;
  assign pop_ok  = i_pop && !empty_q;

  always_comb begin
    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    full_d   = (level_d == (AW+1)'(DEPTH));
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_level = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. Byte stores are queued in a FIFO and drained by
//   a frame FSM as 8N1 frames, or 8E1 frames when UART_TX_PARITY_EN is defined.
//   Ports:
//     i_clk, i_rst_n       : clock and synchronous active-low reset
//     i_wr_en, i_wr_data   : byte push from the memory controller
//     i_clr_ovf            : clears the sticky overflow flag
//     o_full, o_empty, o_level : FIFO status
//     o_busy               : frame FSM not idle
//     o_overflow           : sticky, a push arrived while full
//     o_tx                 : serial line, idle high
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_clr_ovf,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic                          o_tx
);

  tx_state_t        state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             bit_end;
  logic [7:0]       fifo_data;
  logic             fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_wr_en),
    .i_data  (i_wr_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign bit_end = (baud_q == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_data;
`endif
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_data;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A push that hits a full FIFO beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (i_wr_en && fifo_full) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      // The line level is registered from the current state, so it trails
      // the state register by one cycle; frame length is unaffected.
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign o_full     = fifo_full;
  assign o_empty    = fifo_empty;
  assign o_busy     = (state_q != IDLE);
  assign o_overflow = ovf_q;
  assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full, empty, busy, ovf, tx;
  logic [2:0] level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] rx_q[$];
  logic       mon_prev = 1'b1;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_clr_ovf  (clr_ovf),
    .o_full     (full),
    .o_empty    (empty),
    .o_level    (level),
    .o_busy     (busy),
    .o_overflow (ovf),
    .o_tx       (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Serial line decoder: samples mid-bit on the falling clock edge.
  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (mon_prev && !tx && rst_n) begin
        repeat (CPB + CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          v[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
`endif
        repeat (CPB) @(negedge clk);
        rx_q.push_back(v);
      end
      mon_prev = tx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic expect_frame(input logic [7:0] b);
    for (int k = 0; k < FL*CPB; k++) begin
      total_cnt++;
      if (tx !== exp_bit(b, k/CPB))
        $display("FAIL frame_%02h_tx k=%0d got %b exp %b", b, k, tx, exp_bit(b, k/CPB));
      else pass_cnt++;
      step();
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((busy || !empty || !tx) && n < budget) begin
      step();
      n++;
    end
    total_cnt++;
    if (busy || !empty) $display("FAIL %s_idle_timeout busy=%b empty=%b", tag, busy, empty);
    else pass_cnt++;
    repeat (CPB + 2) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hFF; clr_ovf = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({tx, busy, empty, full, ovf, level} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_state got tx=%b busy=%b empty=%b full=%b ovf=%b lvl=%0d exp 1 0 1 0 0 0",
               tx, busy, empty, full, ovf, level);
    else pass_cnt++;
    wr_en = 1'b0; rst_n = 1'b1;
    step();
    total_cnt++;
    if (level !== 3'd0) $display("FAIL reset_release_level got %0d exp 0", level);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    wr_en = 1'b1; wr_data = 8'h55;
    step();                                  // edge N
    wr_en = 1'b0;
    total_cnt++;
    if ({level, empty, tx, busy} !== {3'd1, 1'b0, 1'b1, 1'b0})
      $display("FAIL t1_after_push got lvl=%0d empty=%b tx=%b busy=%b exp 1 0 1 0", level, empty, tx, busy);
    else pass_cnt++;
    step();                                  // edge N+1
    total_cnt++;
    if ({level, tx, busy} !== {3'd0, 1'b1, 1'b1})
      $display("FAIL t1_after_pop got lvl=%0d tx=%b busy=%b exp 0 1 1", level, tx, busy);
    else pass_cnt++;
    step();                                  // edge N+2
    for (int k = 0; k < 10*CPB; k++) begin
      total_cnt++;
      if (tx !== exp_bit(8'h55, k/CPB) || busy !== (k < 10*CPB - 1))
        $display("FAIL t1_bit k=%0d got tx=%b busy=%b exp tx=%b busy=%b",
                 k, tx, busy, exp_bit(8'h55, k/CPB), (k < 10*CPB - 1));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({tx, busy} !== 2'b10) $display("FAIL t1_end got tx=%b busy=%b exp 1 0", tx, busy);
    else pass_cnt++;
    $display("test_single_frame done (0x55)");
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_data = 8'hA3;
    step();                                  // edge M
    total_cnt++;
    if (level !== 3'd1) $display("FAIL t2_level0 got %0d exp 1", level);
    else pass_cnt++;
    wr_data = 8'h0F;
    step();                                  // edge M+1: pop A3, push 0F
    wr_en = 1'b0;
    total_cnt++;
    if (level !== 3'd1) $display("FAIL t2_level1 got %0d exp 1", level);
    else pass_cnt++;
    step();
    total_cnt++;
    if (level !== 3'd1) $display("FAIL t2_level2 got %0d exp 1", level);
    else pass_cnt++;
    expect_frame(8'hA3);
    total_cnt++;
    if (level !== 3'd0) $display("FAIL t2_level3 got %0d exp 0", level);
    else pass_cnt++;
    expect_frame(8'h0F);
    total_cnt++;
    if ({tx, busy} !== 2'b10) $display("FAIL t2_end got tx=%b busy=%b exp 1 0", tx, busy);
    else pass_cnt++;
    $display("test_back_to_back done (0xA3, 0x0F)");
  endtask

  task automatic test_fill(input int n, input logic [7:0] base, input string tag);
    logic [2:0] exp_lvl [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    rx_q.delete();
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = base + 8'(i);
      step();
      total_cnt++;
      if (level !== exp_lvl[i] || ovf !== (i == 5))
        $display("FAIL %s_push%0d got lvl=%0d ovf=%b exp lvl=%0d ovf=%b", tag, i, level, ovf, exp_lvl[i], (i == 5));
      else pass_cnt++;
    end
    wr_en = 1'b0;
    wait_idle(8*FL*CPB, tag);
    total_cnt++;
    if (rx_q.size() != 5) $display("FAIL %s_frames got %0d exp 5", tag, rx_q.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (i >= rx_q.size() || rx_q[i] !== base + 8'(i))
        $display("FAIL %s_byte%0d got %02h exp %02h", tag, i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, base + 8'(i));
      else pass_cnt++;
    end
    $display("%s done (%0d pushes)", tag, n);
  endtask

  task automatic test_overflow_clear();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL t4_clear_first got %b exp 0", ovf);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      step();
    end
    total_cnt++;
    if ({full, ovf} !== 2'b10) $display("FAIL t4_full got full=%b ovf=%b exp 1 0", full, ovf);
    else pass_cnt++;
    clr_ovf = 1'b1;                          // overflowing push together with clear
    step();
    wr_en = 1'b0;
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL t4_set_wins got %b exp 1", ovf);
    else pass_cnt++;
    step();                                  // clear alone
    clr_ovf = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL t4_clear_alone got %b exp 0", ovf);
    else pass_cnt++;
    wait_idle(8*FL*CPB, "t4");
    $display("test_overflow_clear done");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      step();                                // edges P..P+2
    end
    wr_en = 1'b0;
    total_cnt++;
    if (level !== 3'd2) $display("FAIL t5_queued got %0d exp 2", level);
    else pass_cnt++;
    repeat (17) step();                      // at P+19: data bit 3 on the line
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++;
    if ({tx, level, busy, empty, ovf} !== {1'b1, 3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL t5_after_reset got tx=%b lvl=%0d busy=%b empty=%b ovf=%b exp 1 0 0 1 0",
               tx, level, busy, empty, ovf);
    else pass_cnt++;
    begin
      int lows = 0;
      for (int i = 0; i < 15*CPB; i++) begin
        step();
        if (!tx || busy) lows++;
      end
      total_cnt++;
      if (lows != 0) $display("FAIL t5_no_restart got %0d active cycles exp 0", lows);
      else pass_cnt++;
    end
    rx_q.delete();
    $display("test_reset_mid_frame done");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    wr_en = 1'b1; wr_data = 8'h07;
    step();
    wr_en = 1'b0;
    step(); step();
    expect_frame(8'h07);                     // parity bit 1, 44 cycles
    total_cnt++;
    if ({tx, busy} !== 2'b10) $display("FAIL t6_len got tx=%b busy=%b exp 1 0", tx, busy);
    else pass_cnt++;
    wr_en = 1'b1; wr_data = 8'h03;
    step();
    wr_en = 1'b0;
    step(); step();
    expect_frame(8'h03);                     // parity bit 0
    $display("test_parity done (0x07, 0x03)");
  endtask
`endif

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fill(5, 8'h11, "t3a");
    test_fill(6, 8'h61, "t3b");
    test_overflow_clear();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
